qmult_pipe: RTL
===============

Name: qmult_pipe

Overview:
- Pipelined, parametrised successor to the combinational sign-magnitude fixed-point multiplier.
- Multiplies two N-bit sign-magnitude Q-format operands: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fractional.
- Adds per-transaction rounding and saturation modes, overflow reporting, and valid/ready handshakes on input and output.
- Sits between datapath stages that need sustained one-result-per-cycle throughput with backpressure.

Parameters:
- Q, 15, number of fractional bits; legal range 1 to N-2.
- N, 32, total word width including the sign bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  N  operand A, sign-magnitude.
- b  input  N  operand B, sign-magnitude.
- rnd_mode  input  1  0 = truncate, 1 = round half up on magnitude; captured with the operands.
- sat_mode  input  1  0 = wrap, 1 = saturate; captured with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- c  output  N  product, sign-magnitude.
- ovf  output  1  overflow flag for the current c; qualified by out_valid.
- ovf_sticky  output  1  set by any overflow result handshaken out; held until cleared.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit = 0, out_valid = 0, c = 0, ovf = 0, ovf_sticky = 0. in_ready = 1 from the first cycle after reset deassertion. Any in-flight data is discarded.
- Pipeline: three register stages, S1, S2, S3 (S3 drives the output).
  - S1: register sign = a[N-1] XOR b[N-1], magnitudes a[N-2:0] and b[N-2:0], rnd_mode, sat_mode.
  - S2: register the full 2(N-1)-bit unsigned magnitude product, plus sign and modes.
  - S3: round, shift and saturate (below), then register c and ovf.
- Latency: a beat accepted in cycle t gives out_valid in cycle t+3 when there is no stall. Throughput is one beat per cycle.
- Handshake:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - advance = NOT(out_valid AND NOT out_ready). All stages shift only when advance = 1.
  - in_ready = advance, combinational from out_valid and out_ready.
  - While stalled, c, ovf and out_valid hold stable and no stage changes.
  - Bubbles (valid = 0 beats) propagate through the pipeline and are not squeezed out.
- Arithmetic, performed in S3 on product P:
  - Shifted magnitude: M = P >> Q, kept at full width.
  - If rnd_mode = 1: M = M + P[Q-1].
  - Overflow when M > 2^(N-1) - 1. This includes a carry produced by the rounding increment.
  - sat_mode = 1 with overflow: magnitude = all ones, i.e. 2^(N-1) - 1.
  - sat_mode = 0 with overflow: magnitude = M[N-2:0].
  - ovf = overflow in both modes.
  - c = {sign, magnitude}. If the final magnitude is 0, the sign is forced to 0 (no negative zero).
- ovf_sticky:
  - Set on a cycle where out_valid, out_ready and ovf are all 1.
  - If ovf_clr is high in the same cycle as a set condition, the set wins.
  - Otherwise ovf_clr = 1 clears it on the next edge.
- Mode inputs are sampled only on the input transfer; changing them mid-flight does not affect beats already accepted.

Decomposition:
- Package qmult_pkg holds:
  - sign-magnitude helper functions: sign extract, magnitude extract, max magnitude;
  - mode encodings RND_TRUNC/RND_HALF_UP and SAT_WRAP/SAT_CLAMP.
- Sub-module qmult_round_sat: the combinational S3 logic.
  - Inputs: product, sign, modes. Outputs: c_next, ovf_next.
  - Parametrised by Q and N; unit-testable on its own.

Test Plan (N=32, Q=15, no stall unless stated):
- Basic product: a=0x0000C000 (1.5), b=0x00010000 (2.0), rnd=0, sat=1 -> c=0x00018000, ovf=0, exactly 3 cycles after the input transfer.
- Sign handling and negative zero:
  - a=0x8000C000, b=0x00010000 -> c=0x80018000.
  - a=0x80000000, b=0x00008000 -> c=0x00000000, not 0x80000000.
- Rounding: a=0x00000001, b=0x00004000 -> c=0x00000000 with rnd=0; c=0x00000001 with rnd=1.
- Overflow: a=0x7FFFFFFF, b=0x7FFFFFFF:
  - sat=1 -> c=0x7FFFFFFF, ovf=1, ovf_sticky=1 after the output handshake.
  - sat=0 -> c = low 31 bits of (P >> 15) with sign 0, ovf=1.
  - Pulsing ovf_clr afterwards clears ovf_sticky.
- Backpressure: stream 6 back-to-back beats while holding out_ready=0 for 5 cycles:
  - in_ready drops after the pipeline fills;
  - c and out_valid stay stable during the stall;
  - all 6 results emerge in order, with no loss or duplication.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight:
  - out_valid, c, ovf and ovf_sticky go to 0 immediately, without waiting for a clock edge;
  - after release, the first new beat appears exactly 3 cycles after acceptance.

Source files
------------

// File: rtl/qmult_pkg.sv
// Shared definitions for the pipelined sign-magnitude Q-format multiplier:
// mode encodings and sign-magnitude word helpers (words up to 64 bits).
package qmult_pkg;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;
  localparam logic SAT_WRAP    = 1'b0;
  localparam logic SAT_CLAMP   = 1'b1;

  // Largest magnitude representable in an n-bit sign-magnitude word.
  function automatic logic [63:0] sm_max_mag(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic sm_sign(input logic [63:0] w, input int n);
    return w[n - 1];
  endfunction

  function automatic logic [63:0] sm_mag(input logic [63:0] w, input int n);
    return w & sm_max_mag(n);
  endfunction

endpackage

// File: rtl/qmult_round_sat.sv
// Output-stage arithmetic: scale the raw magnitude product back to Q format,
// optionally round, detect overflow and wrap or clamp the result.
module qmult_round_sat
  import qmult_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [2*(N-1)-1:0] prod,
  input  logic               sign,
  input  logic               rnd_mode,
  input  logic               sat_mode,
  output logic [N-1:0]       c_next,
  output logic               ovf_next
);

  localparam int PW = 2 * (N - 1);

  logic [PW:0]    m_s;
  logic [N-2:0]   mag_s;
  logic [63:0]    max_s;

  assign max_s = sm_max_mag(N);

  // Shift, round, overflow-detect and select the final sign-magnitude word.
  always_comb begin
    m_s = {1'b0, prod} >> Q;
    if (rnd_mode == RND_HALF_UP) begin
      m_s = m_s + {{PW{1'b0}}, prod[Q-1]};
    end else begin
      m_s = m_s;
    end
    // The spare top bit of m_s absorbs a rounding carry, so this sees it too.
    ovf_next = |m_s[PW:N-1];
    if (ovf_next && (sat_mode == SAT_CLAMP)) begin
      mag_s = max_s[N-2:0];
    end else begin
      mag_s = m_s[N-2:0];
    end
    if (mag_s == '0) begin
      c_next = {1'b0, mag_s};
    end else begin
      c_next = {sign, mag_s};
    end
  end

endmodule

// File: rtl/qmult_pipe.sv
// Three-stage pipelined sign-magnitude Q-format multiplier with valid/ready
// handshakes, per-beat rounding/saturation modes and overflow reporting.
module qmult_pipe
  import qmult_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rnd_mode,
  input  logic         sat_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);

  localparam int PW = 2 * (N - 1);

  logic              advance_s;
  logic [63:0]       a_w_s, b_w_s, a_mag_s, b_mag_s;
  logic [N-1:0]      c_next_s;
  logic              ovf_next_s;

  logic              v1_r, sign1_r, rnd1_r, sat1_r;
  logic [N-2:0]      ma1_r, mb1_r;
  logic              v2_r, sign2_r, rnd2_r, sat2_r;
  logic [PW-1:0]     prod2_r;
  logic              v3_r, ovf_r, sticky_r;
  logic [N-1:0]      c_r;

  // A full output register that is not being drained freezes every stage.
  assign advance_s = !(v3_r && !out_ready);
  assign in_ready  = advance_s;

  assign a_w_s   = {{(64-N){1'b0}}, a};
  assign b_w_s   = {{(64-N){1'b0}}, b};
  assign a_mag_s = sm_mag(a_w_s, N);
  assign b_mag_s = sm_mag(b_w_s, N);

  // S1: capture operand signs, magnitudes and modes on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      rnd1_r  <= RND_TRUNC;
      sat1_r  <= SAT_WRAP;
      ma1_r   <= '0;
      mb1_r   <= '0;
    end else if (advance_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        sign1_r <= sm_sign(a_w_s, N) ^ sm_sign(b_w_s, N);
        rnd1_r  <= rnd_mode;
        sat1_r  <= sat_mode;
        ma1_r   <= a_mag_s[N-2:0];
        mb1_r   <= b_mag_s[N-2:0];
      end
    end
  end

  // S2: full-width unsigned magnitude product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      rnd2_r  <= RND_TRUNC;
      sat2_r  <= SAT_WRAP;
      prod2_r <= '0;
    end else if (advance_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sign2_r <= sign1_r;
        rnd2_r  <= rnd1_r;
        sat2_r  <= sat1_r;
        prod2_r <= {{(N-1){1'b0}}, ma1_r} * {{(N-1){1'b0}}, mb1_r};
      end
    end
  end

  qmult_round_sat #(.Q(Q), .N(N)) u_round_sat (
    .prod     (prod2_r),
    .sign     (sign2_r),
    .rnd_mode (rnd2_r),
    .sat_mode (sat2_r),
    .c_next   (c_next_s),
    .ovf_next (ovf_next_s)
  );

  // S3: output register; bubbles clear out_valid but leave c/ovf as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r  <= 1'b0;
      c_r   <= '0;
      ovf_r <= 1'b0;
    end else if (advance_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        c_r   <= c_next_s;
        ovf_r <= ovf_next_s;
      end
    end
  end

  // Sticky overflow: a handshaken overflow result takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (v3_r && out_ready && ovf_r) begin
      sticky_r <= 1'b1;
    end else if (ovf_clr) begin
      sticky_r <= 1'b0;
    end
  end

  assign out_valid  = v3_r;
  assign c          = c_r;
  assign ovf        = ovf_r;
  assign ovf_sticky = sticky_r;

endmodule
